// File: rtl/ne_unload_sequencer_p26.sv
// ne_unload_sequencer_p26: walks Lmem row addresses after decode and streams hard-decision words out through a credit-managed FIFO
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   decoder_ready            decode-complete level; its rising edge starts a frame
//   unload_en, unloadAddress Lmem unload read request
//   unload_HDout_vec_regout  Lmem read data, RDLATENCY cycles after unload_en
//   hd_data/hd_valid/hd_last FIFO head word toward the consumer
//   hd_ready                 consumer accepts the head word
//   frame_done               one-cycle pulse once the last word has left
//   busy                     frame in progress (READ or DRAIN)
//   overrun_err              sticky: decoder_ready rose while busy
module ne_unload_sequencer_p26 #(
    parameter int ADDRESSWIDTH = 5,
    parameter int ROWDEPTH     = 20,
    parameter int HDWIDTH      = 32,
    parameter int Kb           = 14,
    parameter int RDLATENCY    = 2,
    parameter int FIFODEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      decoder_ready,
    output logic                      unload_en,
    output logic [ADDRESSWIDTH-1:0]   unloadAddress,
    input  logic [Kb*HDWIDTH-1:0]     unload_HDout_vec_regout,
    output logic [Kb*HDWIDTH-1:0]     hd_data,
    output logic                      hd_valid,
    input  logic                      hd_ready,
    output logic                      hd_last,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      overrun_err
);
    localparam int DW = Kb * HDWIDTH;
    localparam int PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int CW = $clog2(FIFODEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic                    dr_q, rise;
    logic [ADDRESSWIDTH-1:0] addr, last_addr;
    logic [RDLATENCY-1:0]    pipe_v, pipe_l;
    logic [DW-1:0]           mem [FIFODEPTH];
    logic [FIFODEPTH-1:0]    mem_l;
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count, inflight;
    logic                    credit_ok, issue, is_last, push, pop, drained;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFODEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RDLATENCY; i++) inflight = inflight + CW'(pipe_v[i]);
    end

    // Outstanding reads (in flight plus queued) never exceed FIFODEPTH, so
    // every returning word has a free FIFO slot waiting for it.
    assign credit_ok = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(FIFODEPTH);
    assign rise      = decoder_ready & ~dr_q;
    assign issue     = (state == READ) & credit_ok;
    assign is_last   = addr == ADDRESSWIDTH'(ROWDEPTH - 1);
    assign push      = pipe_v[RDLATENCY-1];
    assign pop       = hd_valid & hd_ready;
    assign drained   = (state == DRAIN) & (inflight == '0) & (count == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rise ? READ : IDLE;
            READ:    state_nxt = (issue && is_last) ? DRAIN : READ;
            DRAIN:   state_nxt = drained ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    assign unload_en     = issue;
    assign unloadAddress = issue ? addr : last_addr;
    assign busy          = (state == READ) | ((state == DRAIN) & ~drained);
    assign frame_done    = drained;
    assign hd_valid      = count != '0;
    // Gate the head so the outputs read zero whenever the FIFO is empty.
    assign hd_data       = hd_valid ? mem[rd_ptr] : '0;
    assign hd_last       = hd_valid & mem_l[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dr_q        <= 1'b0;
            addr        <= '0;
            last_addr   <= '0;
            overrun_err <= 1'b0;
            pipe_v      <= '0;
            pipe_l      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state <= state_nxt;
            dr_q  <= decoder_ready;
            if (rise && busy) overrun_err <= 1'b1;
            if (state == IDLE && rise) begin
                addr <= '0;
            end else if (issue) begin
                last_addr <= addr;
                if (!is_last) addr <= addr + 1'b1;
            end
            pipe_v[0] <= issue;
            pipe_l[0] <= issue & is_last;
            for (int i = 1; i < RDLATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]   <= unload_HDout_vec_regout;
            mem_l[wr_ptr] <= pipe_l[RDLATENCY-1];
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) push |-> (count != CW'(FIFODEPTH)));
endmodule

// File: doc/ne_unload_sequencer_p26.md
# ne_unload_sequencer_p26

Sequences the hard-decision unload of the bit-node memory (Lmem) once a frame has finished decoding. On the rising edge of `decoder_ready` it walks `unloadAddress` over all 20 row addresses, driving `unload_en`. It absorbs the registered read latency of Lmem and delivers one 448-bit hard-decision word per address to a downstream valid/ready consumer through a small credit-managed FIFO. It sits between the P=26 row computer and the output interface, and signals frame completion so the next `start` can be issued.

## Interface
Parameters:
- `ADDRESSWIDTH`, 5, width of `unloadAddress`.
- `ROWDEPTH`, 20, row addresses per frame (ceil(511/26)).
- `HDWIDTH`, 32, hard-decision bits per circulant column per address.
- `Kb`, 14, systematic circulant columns; data width is `Kb*HDWIDTH` = 448.
- `RDLATENCY`, 2, cycles from `unload_en` to valid `unload_HDout_vec_regout`.
- `FIFODEPTH`, 4, output FIFO entries; must be at least `RDLATENCY+2`.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `decoder_ready`, in, 1, decode-complete level from the row computer.
- `unload_en`, out, 1, Lmem unload read enable.
- `unloadAddress`, out, `ADDRESSWIDTH`, Lmem unload row address.
- `unload_HDout_vec_regout`, in, 448, Lmem hard-decision read data.
- `hd_data`, out, 448, FIFO head word.
- `hd_valid`, out, 1, head word valid.
- `hd_ready`, in, 1, consumer accepts the head word.
- `hd_last`, out, 1, head word is address `ROWDEPTH-1`.
- `frame_done`, out, 1, one-cycle pulse when the last word has been accepted.
- `busy`, out, 1, high in READ or DRAIN.
- `overrun_err`, out, 1, sticky; set by a `decoder_ready` rising edge while busy.

## Operation
- `decoder_ready` is registered once. A rising edge is register value 0 with current input 1. A level that is held does not retrigger.
- States:
  - IDLE: on a rising edge, clear `addr`, then go to READ.
  - READ: issue a read when `inflight + fifo_count < FIFODEPTH`. An issue drives `unload_en=1` with `unloadAddress=addr`, then increments `addr`. After issuing `ROWDEPTH-1`, go to DRAIN.
  - DRAIN: wait for `inflight==0` and FIFO empty, pulse `frame_done` for one cycle, then go to IDLE.
- `unload_en` is high only on cycles where a read is issued. `unloadAddress` holds its last value when `unload_en` is low.
- In-flight tracking uses a `RDLATENCY`-deep shift register of {valid, last}. When the tail is valid, `unload_HDout_vec_regout` is written into the FIFO with its last tag. The credit check guarantees this write never finds the FIFO full; treat an overflow as a design bug (assertion).
- FIFO: circular with `FIFODEPTH` entries. `hd_data`, `hd_valid` and `hd_last` present the head. A pop occurs when `hd_valid && hd_ready`. A simultaneous push and pop leaves the count unchanged. `hd_data` stays stable while `hd_valid && !hd_ready`.
- `addr` counts 0..`ROWDEPTH-1` and never wraps within a frame. It resets to 0 on entry to READ.
- A `decoder_ready` rising edge during READ or DRAIN is ignored and sets `overrun_err`.
- `rst` asserted mid-frame: return to IDLE immediately, flush the FIFO and in-flight pipe, and discard any partially delivered frame.

## Timing
- Reset values:
  - `unload_en`, `unloadAddress`, `hd_valid`, `hd_last`, `frame_done`, `busy`, `overrun_err` are all 0.
  - `hd_data` is 0.
  - FIFO is empty and the state is IDLE.
- Let the edge of `decoder_ready` be sampled at clock edge T. Then `busy` is high from T+1. The first `unload_en`, with address 0, is at T+1.
- Data for an issue at cycle C is written into the FIFO at edge C+`RDLATENCY`. `hd_valid` asserts at C+`RDLATENCY`+1.
- With `hd_ready` held high, addresses issue on consecutive cycles with no bubbles and one word is delivered per cycle. The frame takes `ROWDEPTH+RDLATENCY+1` cycles from T+1 to `frame_done`.
- `frame_done` is asserted in the cycle after the pop of the `hd_last` word, and `busy` falls in the same cycle.
- Back-pressure: with `hd_ready` low, issues stop once `inflight + fifo_count == FIFODEPTH`, i.e. at most `FIFODEPTH` outstanding reads. Issuing resumes in the cycle after a pop.

## Test plan
- Reset, then pulse `decoder_ready` with `hd_ready=1` and Lmem modelled at latency 2 returning data = address: expect 20 words 0..19 on consecutive cycles, `hd_last` only on word 19, and `frame_done` exactly 23 cycles after the first `unload_en`.
- Hold `hd_ready=0` throughout: expect exactly 4 `unload_en` pulses (addresses 0..3), then `hd_valid=1` with `hd_data` stable at 0. Release `hd_ready` and expect the remaining 16 words in order with none lost or duplicated.
- Drive `hd_ready` with a random 50% pattern: the word sequence must still be 0..19, the FIFO count must never exceed 4, and `unload_en` must never fire at a full credit count.
- Hold `decoder_ready` high across two frames, then re-pulse it mid-frame: expect only one frame, `overrun_err=1` sticky, and no second unload.
- Assert `rst` at address 10 mid-frame: all outputs must be 0 on the next edge. A new `decoder_ready` edge then restarts from address 0.
